// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler
//   Sequences a 1-to-4 bit demultiplexer. Serial bits arrive over a
//   valid/ready handshake. Each bit is assigned to one of four output channels
//   in round-robin order, and disabled channels are skipped. The bit is then
//   held on x/S with a one-hot strobe until that channel's consumer is ready.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   source presents a bit on in_bit
//   in_bit     serial data bit
//   in_ready   scheduler accepts in_bit this cycle (combinational)
//   ch_en      per-channel enable mask, consulted only when a bit is accepted
//   ch_ready   per-channel consumer ready; only ch_ready[S] matters
//   x          registered data bit presented to the demux
//   S          registered demux select (channel index)
//   out_valid  registered one-hot strobe for the pending bit's channel
//   busy       a bit is pending
//   xfer_cnt   delivered-bit counter, wraps modulo 2^CNT_W
module demux_rr_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic [3:0]       ch_en,
  input  logic [3:0]       ch_ready,
  output logic             x,
  output logic [1:0]       S,
  output logic [3:0]       out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       s_d;
  logic             x_d;
  logic [3:0]       ov_d;
  logic [CNT_W-1:0] cnt_d;

  logic             deliver;
  logic             accept;
  logic [1:0]       scan_base;
  logic [1:0]       pick;

  // Returns the first enabled channel, scanning upward from base and wrapping.
  // The loop runs from the farthest offset down, so the nearest hit wins.
  // When no channel is enabled the result is unused, because in_ready is low.
  function automatic logic [1:0] rr_pick(input logic [3:0] en, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] res;
    res = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (en[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    deliver  = (state_q == HOLD) && ch_ready[S];
    in_ready = (|ch_en) && ((state_q == IDLE) || deliver);
    accept   = in_valid && in_ready;
    // A delivery in the same cycle moves the pointer, and the scan has to see
    // that new value already.
    scan_base = deliver ? (S + 2'd1) : ptr_q;
    pick      = rr_pick(ch_en, scan_base);

    state_d = state_q;
    ptr_d   = ptr_q;
    x_d     = x;
    s_d     = S;
    ov_d    = out_valid;
    cnt_d   = xfer_cnt;

    if (deliver) begin
      ptr_d = S + 2'd1;
      cnt_d = xfer_cnt + CNT_W'(1);
    end

    if (accept) begin
      state_d = HOLD;
      x_d     = in_bit;
      s_d     = pick;
      ov_d    = 4'b0001 << pick;
    end else if (deliver) begin
      // x and S keep their last values; only the strobe drops.
      state_d = IDLE;
      ov_d    = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      x         <= 1'b0;
      S         <= 2'd0;
      out_valid <= 4'b0000;
      xfer_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      x         <= x_d;
      S         <= s_d;
      out_valid <= ov_d;
      xfer_cnt  <= cnt_d;
    end
  end

  assign busy = (state_q == HOLD);

endmodule

// File: tb/tb_demux_rr_scheduler.sv
module tb_demux_rr_scheduler;

  localparam int CNT_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic [3:0]       ch_en;
  logic [3:0]       ch_ready;
  logic             x;
  logic [1:0]       S;
  logic [3:0]       out_valid;
  logic             busy;
  logic [CNT_W-1:0] xfer_cnt;

  demux_rr_scheduler #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .ch_ready  (ch_ready),
    .x         (x),
    .S         (S),
    .out_valid (out_valid),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Reference model state: one optional pending bit plus the pointer, the count and the last x/S.
  int m_pend, m_ch, m_ptr, m_cnt, m_x, m_S;
  int n_pend, n_ch, n_ptr, n_cnt, n_x, n_S;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int exp_rdy;
    exp_rdy = (ch_en != 0) && (!m_pend || ch_ready[m_ch]);
    check("m_in_ready",  int'(in_ready),  exp_rdy);
    check("m_busy",      int'(busy),      m_pend);
    check("m_out_valid", int'(out_valid), m_pend ? (1 << m_ch) : 0);
    check("m_x",         int'(x),         m_x);
    check("m_S",         int'(S),         m_S);
    check("m_xfer_cnt",  int'(xfer_cnt),  m_cnt);
  endtask

  task automatic model_next();
    int del, rdy, acc, c;
    n_pend = m_pend; n_ch = m_ch; n_ptr = m_ptr; n_cnt = m_cnt; n_x = m_x; n_S = m_S;
    if (reset) begin
      n_pend = 0; n_ch = 0; n_ptr = 0; n_cnt = 0; n_x = 0; n_S = 0;
    end else begin
      del = m_pend && ch_ready[m_ch];
      rdy = (ch_en != 0) && (!m_pend || del);
      acc = in_valid && rdy;
      if (del) begin
        n_ptr = (m_ch + 1) % 4;
        n_cnt = (m_cnt + 1) % CNT_MOD;
        n_pend = 0;
      end
      if (acc) begin
        c = -1;
        for (int k = 0; k < 4; k++)
          if (c < 0 && ch_en[(n_ptr + k) % 4]) c = (n_ptr + k) % 4;
        n_pend = 1; n_ch = c; n_S = c; n_x = int'(in_bit);
      end
    end
  endtask

  // One clock: compare against the model at the falling edge, advance the
  // model on the rising edge, and return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (chk_on) cmp_model();
    model_next();
    @(posedge clk);
    m_pend = n_pend; m_ch = n_ch; m_ptr = n_ptr; m_cnt = n_cnt; m_x = n_x; m_S = n_S;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int rr_bits [6];
    int rr_cnt  [6];
    int sk_s    [4];
    rr_bits = '{1, 0, 1, 1, 0, 1};
    rr_cnt  = '{0, 1, 2, 3, 0, 1};
    sk_s    = '{1, 3, 1, 3};

    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; ch_en = 4'b0000; ch_ready = 4'b0000;
    tick();
    chk_on = 1;
    reset = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_xfer_cnt",  int'(xfer_cnt),  0);

    // Round-robin over all channels; the counter wraps at 4 for CNT_W=2.
    ch_en = 4'b1111; ch_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_bit = rr_bits[i][0];
      tick();
      check("rr_S",         int'(S),         i % 4);
      check("rr_out_valid", int'(out_valid), 1 << (i % 4));
      check("rr_x",         int'(x),         rr_bits[i]);
      check("rr_xfer_cnt",  int'(xfer_cnt),  rr_cnt[i]);
      check("rr_in_ready",  int'(in_ready),  1);
    end
    in_valid = 1'b0;
    tick();
    check("rr_final_cnt", int'(xfer_cnt),  2);
    check("rr_final_ov",  int'(out_valid), 0);

    // Disabled channels are skipped.
    do_reset();
    ch_en = 4'b1010; ch_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_bit = 1'($urandom_range(0, 1));
      tick();
      check("skip_S",  int'(S),         sk_s[i]);
      check("skip_ov", int'(out_valid), 1 << sk_s[i]);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure on channel 1, then a delivery and an accept in the same cycle.
    do_reset();
    ch_en = 4'b1110; ch_ready = 4'b1101; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    check("bp_S", int'(S), 1);
    ch_en = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", int'(in_ready),  0);
      check("bp_busy",     int'(busy),      1);
      check("bp_S_hold",   int'(S),         1);
      check("bp_ov_hold",  int'(out_valid), 2);
      check("bp_x_hold",   int'(x),         1);
    end
    ch_ready = 4'b1111; in_bit = 1'b0;
    #1;
    check("bp_in_ready_rel", int'(in_ready), 1);
    tick();
    check("bp_next_S",   int'(S),        2);
    check("bp_next_x",   int'(x),        0);
    check("bp_cnt_once", int'(xfer_cnt), 1);
    in_valid = 1'b0;
    tick();
    check("bp_cnt_done", int'(xfer_cnt), 2);

    // No channels enabled: nothing is accepted.
    ch_en = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0_in_ready", int'(in_ready),  0);
      check("en0_ov",       int'(out_valid), 0);
      check("en0_cnt",      int'(xfer_cnt),  2);
    end

    // Clearing the enable of the pending channel does not move the bit.
    ch_en = 4'b1111; ch_ready = 4'b0000; in_valid = 1'b1;
    tick();
    check("clr_S", int'(S), 3);
    in_valid = 1'b0; ch_en = 4'b0111;
    tick();
    check("clr_busy", int'(busy), 1);
    ch_ready = 4'b1000;
    tick();
    check("clr_ov",  int'(out_valid), 0);
    check("clr_cnt", int'(xfer_cnt),  3);
    check("clr_S2",  int'(S),         3);

    // Reset while a bit is pending on channel 2.
    ch_en = 4'b0100; ch_ready = 4'b0000; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    check("mr_S_pre", int'(S),    2);
    check("mr_busy",  int'(busy), 1);
    do_reset();
    check("mr_ov",   int'(out_valid), 0);
    check("mr_busy0",int'(busy),      0);
    check("mr_S",    int'(S),         0);
    check("mr_x",    int'(x),         0);
    check("mr_cnt",  int'(xfer_cnt),  0);
    ch_en = 4'b1111; ch_ready = 4'b1111; in_valid = 1'b1;
    tick();
    check("mr_next_S", int'(S), 0);
    in_valid = 1'b0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_bit   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom_range(0, 15));
      ch_ready = 4'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 4'b1111 : 4'b0000);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
